// File: rtl/gor16_sched_pkg.sv
// Shared constants and types for the gor16 scheduler.
package gor16_sched_pkg;

  // Operand/result width of the shared OR unit.
  localparam int GOR_W = 16;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Client identifiers.
  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  // One-hot per-client vector for a client id.
  function automatic logic [1:0] cli_onehot(input logic cli);
    logic [1:0] v;
    if (cli == CLI1) begin
      v = 2'b10;
    end else begin
      v = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/gor16.sv
// Combinational 16-bit bitwise OR unit shared by the scheduler clients.
module gor16
  import gor16_sched_pkg::*;
(
  input  logic [GOR_W-1:0] op_a,
  input  logic [GOR_W-1:0] op_b,
  output logic [GOR_W-1:0] y
);

  assign y = op_a | op_b;

endmodule

// File: rtl/gor16_sched.sv
// Two-client round-robin scheduler in front of one shared gor16 unit.
// Per-client accumulators hold the last result so chained requests can
// build multi-word OR reductions.
module gor16_sched
  import gor16_sched_pkg::*;
#(
  parameter int WIDTH = GOR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_chain,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy
);

  state_e           state_r;
  state_e           state_s;
  logic             gnt_r;
  logic             last_grant_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] acc_r [2];
  logic [1:0]       rsp_valid_r;
  logic             busy_r;

  logic             grant_s;
  logic             any_req_s;
  logic [1:0]       req_ready_s;
  logic             hs_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] res_next_s;
  logic [1:0]       rsp_valid_s;
  logic             busy_s;

  // The single shared OR unit, fed only from the latched operands.
  gor16 u_gor16 (
    .op_a (op_a_r),
    .op_b (op_b_r),
    .y    (res_next_s)
  );

  // Round-robin pick: a lone requester wins, on contention the client that was not granted last wins.
  always_comb begin
    grant_s   = CLI0;
    any_req_s = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_s   = CLI0;
        any_req_s = 1'b1;
      end
      2'b10: begin
        grant_s   = CLI1;
        any_req_s = 1'b1;
      end
      2'b11: begin
        grant_s   = ~last_grant_r;
        any_req_s = 1'b1;
      end
      default: begin
        grant_s   = CLI0;
        any_req_s = 1'b0;
      end
    endcase
  end

  // Accept only in IDLE and never while reset is asserted; select operands of the granted client.
  always_comb begin
    req_ready_s = 2'b00;
    op_a_s      = req_a0;
    op_b_s      = req_b0;
    if (rst_n && (state_r == S_IDLE) && any_req_s) begin
      req_ready_s = cli_onehot(grant_s);
    end else begin
      req_ready_s = 2'b00;
    end
    if (grant_s == CLI1) begin
      op_a_s = req_a1;
      op_b_s = req_chain[1] ? acc_r[1] : req_b1;
    end else begin
      op_a_s = req_a0;
      op_b_s = req_chain[0] ? acc_r[0] : req_b0;
    end
  end

  assign hs_s      = |(req_valid & req_ready_s);
  assign req_ready = req_ready_s;

  // Next-state logic plus the next values of the registered response flags.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (hs_s) begin
          state_s = S_EXEC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        state_s = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[gnt_r]) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    rsp_valid_s = 2'b00;
    if (state_s == S_RESP) begin
      rsp_valid_s = cli_onehot(gnt_r);
    end else begin
      rsp_valid_s = 2'b00;
    end
    busy_s = (state_s != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch on accept, result and accumulator write at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_r        <= CLI0;
      last_grant_r <= CLI1;
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      res_r        <= {WIDTH{1'b0}};
      acc_r[0]     <= {WIDTH{1'b0}};
      acc_r[1]     <= {WIDTH{1'b0}};
    end else begin
      if (hs_s) begin
        gnt_r        <= grant_s;
        last_grant_r <= grant_s;
        op_a_r       <= op_a_s;
        op_b_r       <= op_b_s;
      end
      if (state_r == S_EXEC) begin
        res_r        <= res_next_s;
        acc_r[gnt_r] <= res_next_s;
      end
    end
  end

  // Registered response-valid and busy flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_y     = res_r;
  assign busy      = busy_r;

endmodule
